hazard_stall_ctrl: RTL and testbench

Pipeline interlock controller for the 5-stage MIPS core. It decodes the instructions in D, E and M and asserts `stall` to freeze PC and the IF/ID register and insert a bubble into ID/EX for any hazard that forwarding cannot resolve. It also sequences the multi-cycle HI/LO multiply/divide unit with a start pulse and a busy counter, and keeps a saturating stall-cycle counter for performance measurement. It sits beside the forwarding muxes, and its `stall` output drives the pipeline-register enables.

---
 rtl/pipe_pkg.sv | 105 ++++++++++
 rtl/hazard_stall_ctrl_md_seq.sv | 77 +++++++
 rtl/hctrl.sv | 62 ++++++
 rtl/hazard_stall_ctrl.sv | 134 +++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcode/funct constants, decoded-stage record,
// HI/LO sequencer states and small instruction classification helpers.
package pipe_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FUNCT_SLL   = 6'h00;
    localparam logic [5:0] FUNCT_SRL   = 6'h02;
    localparam logic [5:0] FUNCT_SRA   = 6'h03;
    localparam logic [5:0] FUNCT_SLLV  = 6'h04;
    localparam logic [5:0] FUNCT_SRLV  = 6'h06;
    localparam logic [5:0] FUNCT_SRAV  = 6'h07;
    localparam logic [5:0] FUNCT_JR    = 6'h08;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
    localparam logic [5:0] FUNCT_ADD   = 6'h20;
    localparam logic [5:0] FUNCT_ADDU  = 6'h21;
    localparam logic [5:0] FUNCT_SUB   = 6'h22;
    localparam logic [5:0] FUNCT_SUBU  = 6'h23;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_XOR   = 6'h26;
    localparam logic [5:0] FUNCT_NOR   = 6'h27;
    localparam logic [5:0] FUNCT_SLT   = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU  = 6'h2B;

    // Stage indices into the per-stage decode arrays
    localparam int S_D = 0;
    localparam int S_E = 1;
    localparam int S_M = 2;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // One decoded stage, as produced by hctrl
    typedef struct packed {
        logic       b_type;
        logic       cal_r;
        logic       cal_i;
        logic       load;
        logic       store;
        logic       jr;
        logic       jal;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } dec_t;

    // mult / multu / div / divu
    function automatic logic is_md_op(input logic [5:0] opcode, input logic [5:0] funct);
        return (opcode == OP_RTYPE) &&
               ((funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
                (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU));
    endfunction

    // mfhi / mflo / mthi / mtlo
    function automatic logic is_hilo_use(input logic [5:0] opcode, input logic [5:0] funct);
        return (opcode == OP_RTYPE) &&
               ((funct == FUNCT_MFHI) || (funct == FUNCT_MFLO) ||
                (funct == FUNCT_MTHI) || (funct == FUNCT_MTLO));
    endfunction

    // mthi / mtlo read rs; mfhi / mflo do not
    function automatic logic is_hilo_write(input logic [5:0] opcode, input logic [5:0] funct);
        return (opcode == OP_RTYPE) &&
               ((funct == FUNCT_MTHI) || (funct == FUNCT_MTLO));
    endfunction

    // div / divu (only meaningful when is_md_op is true)
    function automatic logic is_div_funct(input logic [5:0] funct);
        return (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_seq.sv
// HI/LO multiply/divide sequencer: accepts an md op sitting in E while idle,
// then reports busy for exactly MULT_CYCLES or DIV_CYCLES cycles.
module md_seq
    import pipe_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic md_op_E,
    input  logic is_div_E,
    output logic md_start,
    output logic md_busy
);

    if ((MULT_CYCLES < 1) || (MULT_CYCLES > 15)) begin : g_bad_mult
        $error("md_seq: MULT_CYCLES must be in 1..15");
    end
    if ((DIV_CYCLES < 1) || (DIV_CYCLES > 15)) begin : g_bad_div
        $error("md_seq: DIV_CYCLES must be in 1..15");
    end

    // Counter reload values: busy lasts through cnt = N-1 .. 0
    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    md_state_t  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    // State and countdown registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: IDLE launches on an md op in E, BUSY counts down to zero
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (md_op_E) begin
                    state_d = MD_BUSY;
                    cnt_d   = is_div_E ? DIV_LOAD : MULT_LOAD;
                end
            end
            MD_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Outputs: start is held off during reset; busy is a pure state decode
    always_comb begin
        md_start = rst_n && (state_q == MD_IDLE) && md_op_E;
        md_busy  = (state_q == MD_BUSY);
    end

    // An md op reaching E while busy means the HI/LO interlock was bypassed
    md_err: assert property (@(posedge clk) disable iff (!rst_n)
                             !((state_q == MD_BUSY) && md_op_E));

endmodule

// File: rtl/hctrl.sv
// Instruction class decoder shared by the hazard logic; one copy per stage.
// An all-zero instruction is a bubble and decodes to no class at all.
module hctrl
    import pipe_pkg::*;
(
    input  logic [31:0] instr,
    output logic        b_type,
    output logic        cal_r,
    output logic        cal_i,
    output logic        load,
    output logic        store,
    output logic        jr,
    output logic        jal,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       bubble;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign bubble = (instr == 32'd0);
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];

    // Classify the instruction by opcode and, for R-type, by funct
    always_comb begin
        b_type = 1'b0;
        cal_r  = 1'b0;
        cal_i  = 1'b0;
        load   = 1'b0;
        store  = 1'b0;
        jr     = 1'b0;
        jal    = 1'b0;
        if (!bubble) begin
            case (opcode)
                OP_RTYPE: begin
                    case (funct)
                        FUNCT_ADD, FUNCT_ADDU, FUNCT_SUB, FUNCT_SUBU,
                        FUNCT_AND, FUNCT_OR, FUNCT_XOR, FUNCT_NOR,
                        FUNCT_SLT, FUNCT_SLTU, FUNCT_SLL, FUNCT_SRL,
                        FUNCT_SRA, FUNCT_SLLV, FUNCT_SRLV, FUNCT_SRAV: cal_r = 1'b1;
                        FUNCT_JR:                                      jr    = 1'b1;
                        default:                                       ;
                    endcase
                end
                OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:                      b_type = 1'b1;
                OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                OP_ANDI, OP_ORI, OP_XORI, OP_LUI:                      cal_i  = 1'b1;
                OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:                   load   = 1'b1;
                OP_SB, OP_SH, OP_SW:                                   store  = 1'b1;
                OP_JAL:                                                jal    = 1'b1;
                default:                                               ;
            endcase
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock for the 5-stage core: detects hazards that forwarding
// cannot cover, sequences the HI/LO unit and counts stalled cycles.
module hazard_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instrD,
    input  logic [31:0] instrE,
    input  logic [31:0] instrM,
    output logic        stall,
    output logic        md_start,
    output logic        md_is_div,
    output logic        md_busy,
    output logic [31:0] stall_cycles
);

    logic [2:0][31:0] instr_s;
    dec_t [2:0]       dec_s;

    assign instr_s = {instrM, instrE, instrD};

    for (genvar gi = 0; gi < 3; gi++) begin : g_dec
        logic       b_type, cal_r, cal_i, load, store, jr, jal;
        logic [4:0] rs, rt, rd;

        hctrl u_hctrl (
            .instr  (instr_s[gi]),
            .b_type (b_type),
            .cal_r  (cal_r),
            .cal_i  (cal_i),
            .load   (load),
            .store  (store),
            .jr     (jr),
            .jal    (jal),
            .rs     (rs),
            .rt     (rt),
            .rd     (rd)
        );

        assign dec_s[gi] = {b_type, cal_r, cal_i, load, store, jr, jal, rs, rt, rd};
    end

    // Several decoded fields (jal everywhere, store in E/M, ...) have no bearing on interlocks
    logic unused_dec;
    assign unused_dec = ^dec_s;

    dec_t dD, dE, dM;
    assign dD = dec_s[S_D];
    assign dE = dec_s[S_E];
    assign dM = dec_s[S_M];

    logic       md_op_D, hilo_use_D, hilo_wr_D, md_op_E, is_div_E;
    logic       use_rs_D, use_rt_D, branch_D;
    logic [4:0] wr_E;
    logic       s1_load_use, s2_branch_e, s3_branch_m, s4_hilo;

    // Local md/hilo classification and register-use flags for D
    always_comb begin
        md_op_D    = is_md_op(instrD[31:26], instrD[5:0]);
        hilo_use_D = is_hilo_use(instrD[31:26], instrD[5:0]);
        hilo_wr_D  = is_hilo_write(instrD[31:26], instrD[5:0]);
        md_op_E    = is_md_op(instrE[31:26], instrE[5:0]);
        is_div_E   = md_op_E && is_div_funct(instrE[5:0]);
        use_rs_D   = dD.cal_r || dD.cal_i || dD.load || dD.store ||
                     dD.b_type || dD.jr || md_op_D || hilo_wr_D;
        use_rt_D   = dD.cal_r || dD.store || dD.b_type || md_op_D;
        branch_D   = dD.b_type || dD.jr;
    end

    // Destination written by the instruction in E ($0 means nothing written)
    always_comb begin
        wr_E = 5'd0;
        if (dE.cal_r) begin
            wr_E = dE.rd;
        end else if (dE.cal_i || dE.load) begin
            wr_E = dE.rt;
        end
    end

    // True when a nonzero register is read by D as rs or rt
    function automatic logic d_reads(input logic [4:0] r, input dec_t d,
                                     input logic urs, input logic urt);
        return (r != 5'd0) && ((urs && (d.rs == r)) || (urt && (d.rt == r)));
    endfunction

    // The four interlock conditions; any one of them freezes the front end
    always_comb begin
        s1_load_use = dE.load && d_reads(dE.rt, dD, use_rs_D, use_rt_D);
        s2_branch_e = branch_D && d_reads(wr_E, dD, use_rs_D, use_rt_D);
        s3_branch_m = branch_D && dM.load && d_reads(dM.rt, dD, use_rs_D, use_rt_D);
        s4_hilo     = (md_op_D || hilo_use_D) && (md_busy || md_op_E);
        stall       = s1_load_use || s2_branch_e || s3_branch_m || s4_hilo;
    end

    md_seq #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .md_op_E  (md_op_E),
        .is_div_E (is_div_E),
        .md_start (md_start),
        .md_busy  (md_busy)
    );

    assign md_is_div = is_div_E;

    logic [31:0] stall_cycles_q, stall_cycles_d;

    // Saturating count of stalled cycles
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: hand-sequenced pipeline contents,
// immediate assertions against hand-computed expectations.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instrD, instrE, instrM;
    logic        stall, md_start, md_is_div, md_busy;
    logic [31:0] stall_cycles;

    int n_assert = 0;
    int n_fail   = 0;

    hazard_stall_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instrD       (instrD),
        .instrE       (instrE),
        .instrM       (instrM),
        .stall        (stall),
        .md_start     (md_start),
        .md_is_div    (md_is_div),
        .md_busy      (md_busy),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                          input logic [5:0] funct);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, funct};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs,
                                          input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
        $display("check %-14s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Move 1 ns past the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present new pipeline contents and let the combinational outputs settle
    task automatic put(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m);
        instrD = d;
        instrE = e;
        instrM = m;
        #1;
    endtask

    logic [31:0] lw8, lw0, add_98_1, add_90_1, add_900, add_91_8, addi_81;
    logic [31:0] lw4, beq45, add_512, ori31, jr31;
    logic [31:0] mult12, mflo3, divu12, div34, mfhi5;

    initial begin
        lw8      = itype(6'h23, 0, 8, 16'h0000);
        lw0      = itype(6'h23, 0, 0, 16'h0000);
        lw4      = itype(6'h23, 0, 4, 16'h0010);
        add_98_1 = rtype(8, 1, 9, 6'h20);
        add_90_1 = rtype(0, 1, 9, 6'h20);
        add_900  = rtype(0, 0, 9, 6'h20);
        add_91_8 = rtype(1, 8, 9, 6'h20);
        addi_81  = itype(6'h08, 1, 8, 16'h0004);
        beq45    = itype(6'h04, 4, 5, 16'h0003);
        add_512  = rtype(1, 2, 5, 6'h20);
        ori31    = itype(6'h0D, 0, 31, 16'h0001);
        jr31     = rtype(31, 0, 0, 6'h08);
        mult12   = rtype(1, 2, 0, 6'h18);
        mflo3    = rtype(0, 0, 3, 6'h12);
        divu12   = rtype(1, 2, 0, 6'h1B);
        div34    = rtype(3, 4, 0, 6'h1A);
        mfhi5    = rtype(0, 0, 5, 6'h10);

        // ---- reset: mult in E must not start while rst_n is low ----
        rst_n = 1'b0;
        put(32'd0, mult12, 32'd0);
        chk("rst_busy", 32'(md_busy), 32'd0);
        chk("rst_count", stall_cycles, 32'd0);
        chk("rst_start", 32'(md_start), 32'd0);
        chk("rst_isdiv", 32'(md_is_div), 32'd0);
        tick();
        tick();
        put(32'd0, 32'd0, 32'd0);
        rst_n = 1'b1;
        chk("rst_stall", 32'(stall), 32'd0);

        // ---- load-use ----
        tick(); put(add_98_1, lw8, 32'd0);      // c1
        chk("lu_stall", 32'(stall), 32'd1);
        tick(); put(add_98_1, 32'd0, lw8);      // c2
        chk("lu_release", 32'(stall), 32'd0);
        chk("lu_count", stall_cycles, 32'd1);
        tick(); put(32'd0, add_98_1, 32'd0);    // c3
        chk("lu_flow", 32'(stall), 32'd0);
        tick(); put(add_90_1, lw8, 32'd0);      // c4
        chk("lu_nodep", 32'(stall), 32'd0);
        tick(); put(add_900, lw0, 32'd0);       // c5
        chk("lu_reg0", 32'(stall), 32'd0);
        tick(); put(add_91_8, lw8, 32'd0);      // c6
        chk("lu_rt_stall", 32'(stall), 32'd1);
        tick(); put(add_91_8, 32'd0, lw8);      // c7
        chk("lu_rt_rel", 32'(stall), 32'd0);
        chk("lu_rt_count", stall_cycles, 32'd2);
        tick(); put(addi_81, lw8, 32'd0);       // c8
        chk("lu_calirt", 32'(stall), 32'd0);

        // ---- branch vs load: S2 then S3 ----
        tick(); put(beq45, lw4, 32'd0);         // c9
        chk("bl_stall1", 32'(stall), 32'd1);
        tick(); put(beq45, 32'd0, lw4);         // c10
        chk("bl_stall2", 32'(stall), 32'd1);
        tick(); put(32'd0, beq45, 32'd0);       // c11
        chk("bl_release", 32'(stall), 32'd0);
        chk("bl_count", stall_cycles, 32'd4);

        // ---- branch vs cal_r in E ----
        tick(); put(beq45, add_512, 32'd0);     // c12
        chk("bc_stall", 32'(stall), 32'd1);
        tick(); put(beq45, 32'd0, add_512);     // c13
        chk("bc_release", 32'(stall), 32'd0);
        chk("bc_count", stall_cycles, 32'd5);

        // ---- jr vs cal_i in E ----
        tick(); put(jr31, ori31, 32'd0);        // c14
        chk("jr_stall", 32'(stall), 32'd1);
        tick(); put(jr31, 32'd0, ori31);        // c15
        chk("jr_release", 32'(stall), 32'd0);
        chk("jr_count", stall_cycles, 32'd6);

        // ---- mult then mflo ----
        tick(); put(mflo3, mult12, 32'd0);      // c16
        chk("mu_start", 32'(md_start), 32'd1);
        chk("mu_isdiv", 32'(md_is_div), 32'd0);
        chk("mu_stall0", 32'(stall), 32'd1);
        chk("mu_busy0", 32'(md_busy), 32'd0);
        for (int i = 0; i < 5; i++) begin       // c17..c21
            tick(); put(mflo3, 32'd0, mult12 & 32'd0);
            chk("mu_busy", 32'(md_busy), 32'd1);
            chk("mu_stall", 32'(stall), 32'd1);
            chk("mu_nostart", 32'(md_start), 32'd0);
        end
        tick(); put(mflo3, 32'd0, 32'd0);       // c22
        chk("mu_idle", 32'(md_busy), 32'd0);
        chk("mu_release", 32'(stall), 32'd0);
        chk("mu_count", stall_cycles, 32'd12);
        tick(); put(32'd0, mflo3, 32'd0);       // c23
        chk("mflo_e_start", 32'(md_start), 32'd0);

        // ---- divu then back-to-back div ----
        tick(); put(div34, divu12, 32'd0);      // c24
        chk("dv_start", 32'(md_start), 32'd1);
        chk("dv_isdiv", 32'(md_is_div), 32'd1);
        chk("dv_stall0", 32'(stall), 32'd1);
        for (int i = 0; i < 10; i++) begin      // c25..c34
            tick(); put(div34, 32'd0, 32'd0);
            chk("dv_busy", 32'(md_busy), 32'd1);
            chk("dv_stall", 32'(stall), 32'd1);
        end
        tick(); put(div34, 32'd0, 32'd0);       // c35
        chk("dv_idle", 32'(md_busy), 32'd0);
        chk("dv_release", 32'(stall), 32'd0);
        chk("dv_count", stall_cycles, 32'd23);

        // ---- reset in the middle of the second div ----
        tick(); put(32'd0, div34, 32'd0);       // c36
        chk("d2_start", 32'(md_start), 32'd1);
        chk("d2_nostall", 32'(stall), 32'd0);
        tick(); put(32'd0, 32'd0, div34);       // c37
        chk("d2_busy1", 32'(md_busy), 32'd1);
        tick(); put(32'd0, 32'd0, 32'd0);       // c38
        chk("d2_busy2", 32'(md_busy), 32'd1);
        chk("d2_count", stall_cycles, 32'd23);
        tick(); put(mfhi5, 32'd0, 32'd0);       // c39
        chk("d2_busy3", 32'(md_busy), 32'd1);
        chk("d2_hilo", 32'(stall), 32'd1);
        rst_n = 1'b0;
        put(mfhi5, div34, 32'd0);
        chk("mr_busy", 32'(md_busy), 32'd0);
        chk("mr_count", stall_cycles, 32'd0);
        chk("mr_start", 32'(md_start), 32'd0);
        chk("mr_stall", 32'(stall), 32'd1);
        tick();
        put(32'd0, 32'd0, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("mr_after", stall_cycles, 32'd0);
        chk("mr_idle", 32'(md_busy), 32'd0);

        // ---- saturation of the stall counter ----
        force dut.stall_cycles_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cycles_q;
        #1;
        chk("sat_preload", stall_cycles, 32'hFFFF_FFFE);
        put(add_98_1, lw8, 32'd0);
        chk("sat_stall", 32'(stall), 32'd1);
        tick();
        chk("sat_max1", stall_cycles, 32'hFFFF_FFFF);
        tick();
        chk("sat_max2", stall_cycles, 32'hFFFF_FFFF);
        tick();
        chk("sat_max3", stall_cycles, 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
